sap_1_controller_sequencer: RTL
===============================

Name: sap_1_controller_sequencer

Overview:
- Sequential front end of the SAP-1 controller.
- Generates the one-hot T-state ring (T1..T6) and registered instruction-decode strobes (LDA/ADD/SUB/OUT).
- The control-word decode matrix consumes these outputs.
- Latches the IR opcode nibble at the fetch/execute boundary, implements HLT, and flags illegal opcodes.

Parameters:
- OPC_LDA, 4'b0000, opcode decoded as LDA
- OPC_ADD, 4'b0001, opcode decoded as ADD
- OPC_SUB, 4'b0010, opcode decoded as SUB
- OPC_OUT, 4'b1110, opcode decoded as OUT
- OPC_HLT, 4'b1111, opcode decoded as HLT

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- CLR  input  1  reset, synchronous, active-high
- opcode  input  4  IR upper nibble; sampled only on the T3->T4 edge
- ring_counter  output  6  one-hot T-state, bit 1 = T1 ... bit 6 = T6; all-zero when halted
- LDA  output  1  registered decode, held T4..T6
- ADD  output  1  registered decode, held T4..T6
- SUB  output  1  registered decode, held T4..T6
- OUT  output  1  registered decode, held T4..T6
- HLT  output  1  high while halted
- illegal_op  output  1  one-cycle pulse during T4 for an unrecognised opcode

Behaviour:
- Reset (CLR high at a rising edge): ring_counter=6'b000001, LDA=ADD=SUB=OUT=0, HLT=0, illegal_op=0. CLR has priority over every other event, including halted state and a mid-instruction T-state.
- Ring sequencing: each edge rotates one position: T1->T2->T3->T4->T5->T6->T1. No other one-hot value is ever produced.
- Any non-one-hot ring value (not reachable in normal operation) recovers to T1 on the next edge.
- Opcode capture: on the edge leaving T3 (ring_counter[3]=1), opcode is compared against the parameters and the decode registers load.
  - Exactly one of LDA/ADD/SUB/OUT goes high, or none.
  - The value is valid from the first cycle of T4 and holds through T6.
  - Decodes clear on the edge leaving T6, so they are 0 during T1..T3 (fetch).
  - opcode changes at any other time have no effect.
- HLT: if the captured opcode equals OPC_HLT, the T3->T4 edge sets HLT=1 and ring_counter=6'b000000 instead of T4. All decodes stay 0.
  - While halted, the state is frozen until CLR.
- Illegal opcode (none of the five parameters): the T3->T4 edge sets illegal_op=1 for the T4 cycle only. Decodes stay 0 and the ring continues T4..T6 as a NOP.
- Latency:
  - Ring: 1 clock per T-state, 6 clocks per instruction.
  - Decode: visible 1 clock after the T3 sample.
- Parameter collision (two parameters equal): priority LDA > ADD > SUB > OUT > HLT.

Optional Feature:
- Macro: SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN
- When defined, the block adds input ports `step_mode` (1) and `step` (1), plus an internal step-edge register.
- With step_mode=1, the ring and decode registers advance only on a cycle where step rises (step=1 and previous step=0), exactly one T-state per rising step.
- A held step does not repeat.
- With step_mode=0, the block behaves as free-running.
- CLR also clears the step-edge register.
- Mode change takes effect on the next edge without disturbing the current T-state.
- When undefined, neither port exists and the block always free-runs.

Test Plan:
- Reset then free-run 12 clocks, opcode=4'b0000 -> ring_counter sequence 000001, 000010, 000100, 001000, 010000, 100000, repeating; LDA=1 only while ring_counter is 001000, 010000 or 100000.
- opcode=4'b0010 at T3, changed to 4'b0001 during T4 -> SUB=1 for T4..T6, ADD stays 0; opcode=4'b0001 at the next T3 -> ADD=1 in the following T4.
- opcode=4'b1111 at T3 -> next edge HLT=1, ring_counter=000000; 20 further clocks with varying opcode -> unchanged; CLR pulse -> ring_counter=000001, HLT=0.
- opcode=4'b0111 at T3 -> illegal_op=1 for exactly one cycle (T4), all decodes 0, ring reaches T6 then T1.
- CLR asserted during T5 of an ADD -> next edge ring_counter=000001, ADD=0; CLR held 3 cycles -> ring stays 000001.
- With SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN defined, step_mode=1: step held high 5 clocks -> exactly one advance; 3 separate step pulses from T1 -> ring_counter=001000.

Source files
------------

// File: rtl/sap_1_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sap_1_controller_sequencer
// Purpose  : Sequential front end of the SAP-1 controller. Generates the
//            one-hot T-state ring (T1..T6) and the registered instruction
//            decode strobes (LDA/ADD/SUB/OUT). It latches the opcode at the
//            fetch/execute boundary, halts on HLT and flags illegal opcodes.
// Options  : SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN adds the step_mode and
//            step inputs. In step mode, each rising edge of step advances
//            the sequencer by exactly one T-state.
// Revision : 1.0 - initial release
// ============================================================================
module sap_1_controller_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR,
`ifdef SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  input  logic [3:0] opcode,
  output logic [6:1] ring_counter,
  output logic       LDA,
  output logic       ADD,
  output logic       SUB,
  output logic       OUT,
  output logic       HLT,
  output logic       illegal_op
);

  // Bit n of the ring is T-state Tn. The reset value therefore reads 6'b000001.
  localparam logic [6:1] C_RING_T1   = 6'b000001;
  localparam logic [6:1] C_RING_HALT = 6'b000000;

  // Sequencer state. Every output is taken directly from one of these flops.
  logic [6:1] ring_q, ring_d;
  logic       lda_q, lda_d;
  logic       add_q, add_d;
  logic       sub_q, sub_d;
  logic       out_q, out_d;
  logic       hlt_q, hlt_d;
  logic       ill_q, ill_d;

  // Qualifies every state update. It is always 1 when the block free-runs.
  logic       advance;

  // Opcode classification. A priority chain resolves parameter collisions
  // as LDA > ADD > SUB > OUT > HLT.
  logic       dec_lda, dec_add, dec_sub, dec_out, dec_hlt, dec_ill;

  // A value is a legal ring state only when exactly one bit is set. All
  // other values fall back to T1, except the all-zero value held by HLT.
  function automatic logic is_one_hot(input logic [6:1] v);
    return (v != 6'b000000) && ((v & (v - 6'b000001)) == 6'b000000);
  endfunction

`ifdef SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN
  // Previous value of step, used to detect its rising edge.
  logic step_prev_q, step_prev_d;

  // Step mode advances only on a rising edge of step. Holding step high
  // therefore does not keep advancing the sequencer.
  always_comb begin
    step_prev_d = step;
    advance     = !step_mode || (step && !step_prev_q);
  end
`else
  // Without single-step support, the sequencer moves on every clock.
  always_comb begin
    advance = 1'b1;
  end
`endif

  // Classify the opcode. Only the T3 exit consumes this result.
  always_comb begin
    dec_lda = 1'b0;
    dec_add = 1'b0;
    dec_sub = 1'b0;
    dec_out = 1'b0;
    dec_hlt = 1'b0;
    dec_ill = 1'b0;
    if (opcode == OPC_LDA) begin
      dec_lda = 1'b1;
    end else if (opcode == OPC_ADD) begin
      dec_add = 1'b1;
    end else if (opcode == OPC_SUB) begin
      dec_sub = 1'b1;
    end else if (opcode == OPC_OUT) begin
      dec_out = 1'b1;
    end else if (opcode == OPC_HLT) begin
      dec_hlt = 1'b1;
    end else begin
      dec_ill = 1'b1;
    end
  end

  // Next-state logic for the ring, the decode strobes, halt and the illegal
  // pulse.
  always_comb begin
    ring_d = ring_q;
    lda_d  = lda_q;
    add_d  = add_q;
    sub_d  = sub_q;
    out_d  = out_q;
    hlt_d  = hlt_q;
    ill_d  = ill_q;

    if (!advance || hlt_q) begin
      // Hold the current state. While halted, only CLR releases it.
    end else if (!is_one_hot(ring_q)) begin
      // Recover from a corrupted ring by restarting a clean fetch.
      ring_d = C_RING_T1;
      lda_d  = 1'b0;
      add_d  = 1'b0;
      sub_d  = 1'b0;
      out_d  = 1'b0;
      ill_d  = 1'b0;
    end else begin
      ring_d = {ring_q[5:1], ring_q[6]};
      // The illegal flag lasts for the T4 state only.
      ill_d  = 1'b0;

      if (ring_q[3]) begin
        // The fetch/execute boundary is the only point where the opcode
        // is sampled.
        lda_d = dec_lda;
        add_d = dec_add;
        sub_d = dec_sub;
        out_d = dec_out;
        ill_d = dec_ill;
        if (dec_hlt) begin
          hlt_d  = 1'b1;
          ring_d = C_RING_HALT;
        end
      end

      if (ring_q[6]) begin
        // Clear the strobes so that they read 0 throughout the next fetch.
        lda_d = 1'b0;
        add_d = 1'b0;
        sub_d = 1'b0;
        out_d = 1'b0;
      end
    end
  end

  // Sequencer state registers. CLR overrides every other condition.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring_q <= C_RING_T1;
      lda_q  <= 1'b0;
      add_q  <= 1'b0;
      sub_q  <= 1'b0;
      out_q  <= 1'b0;
      hlt_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      ring_q <= ring_d;
      lda_q  <= lda_d;
      add_q  <= add_d;
      sub_q  <= sub_d;
      out_q  <= out_d;
      hlt_q  <= hlt_d;
      ill_q  <= ill_d;
    end
  end

`ifdef SAP_1_CONTROLLER_SEQUENCER_SINGLE_STEP_EN
  // Step edge detector. CLR clears it, so a step that is already high when
  // CLR drops still counts as a new edge.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
    end
  end
`endif

  // Drive the outputs straight from the registers.
  always_comb begin
    ring_counter = ring_q;
    LDA          = lda_q;
    ADD          = add_q;
    SUB          = sub_q;
    OUT          = out_q;
    HLT          = hlt_q;
    illegal_op   = ill_q;
  end

endmodule
`default_nettype wire
